// File: rtl/timer_pkg.sv
// Shared definitions for the keypad entry stage of the countdown timer:
// key codes, FSM state encoding, digit bundle type and default limits.
package timer_pkg;

  // Non-digit key codes; 4'hC-4'hF carry no meaning and are ignored.
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_LOAD  = 4'hB;

  // Default limits for the loadable time.
  localparam int MIN_MAX_DEF      = 9;
  localparam int SEC_TENS_MAX_DEF = 5;

  // Entry FSM: IDLE (nothing typed), ENTRY (digits typed),
  // NORM (one cycle to register normalised data), LOAD (loadn low).
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_NORM  = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  // One M:ST:SO time value as three BCD digits.
  typedef struct packed {
    logic [3:0] minute;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } time_digits_t;

  // True for the decimal digit keys 0-9.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/time_normalizer.sv
// Combinational normaliser for a raw M:ST:SO entry.
// A seconds-tens digit above SEC_TENS_MAX is folded into a minute carry
// (the minute counter adds the carry itself, so the minute digit is passed
// through unchanged). If no minute headroom is left the value is clamped to
// the largest loadable time and the clamp flag is raised.
module time_normalizer
  import timer_pkg::*;
#(
  parameter int MIN_MAX      = MIN_MAX_DEF,
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
  input  time_digits_t raw,
  output time_digits_t norm,
  output logic         carry,
  output logic         clamp
);

  localparam logic [3:0] MIN_MAX_D      = 4'(MIN_MAX);
  localparam logic [3:0] SEC_TENS_MAX_D = 4'(SEC_TENS_MAX);

  // Pick pass-through, carry-fold or clamp from the raw digits.
  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // if/else leaves a signal unassigned, which would infer a latch.
    norm  = raw;
    carry = 1'b0;
    clamp = 1'b0;
    if (raw.sec_tens <= SEC_TENS_MAX_D) begin
      // Already a legal time; load as typed.
      norm = raw;
    end else if (raw.minute < MIN_MAX_D) begin
      // 60 seconds become one minute; the counter adds it via carry_out.
      norm.sec_tens = raw.sec_tens - 4'd6;
      carry         = 1'b1;
    end else begin
      // No room for another minute: saturate to the largest time.
      norm.minute   = MIN_MAX_D;
      norm.sec_tens = SEC_TENS_MAX_D;
      norm.sec_ones = 4'd9;
      clamp         = 1'b1;
    end
  end

endmodule

// File: rtl/keypad_time_loader.sv
// Keypad entry stage ahead of the timer's minute/second counters.
// Collects up to three digits (M:ST:SO), and on LOAD drives the counters'
// parallel-load interface with normalised digits, a one-cycle active-low
// loadn pulse and a minute carry. Every output is a register.
module keypad_time_loader
  import timer_pkg::*;
#(
  parameter int MIN_MAX      = MIN_MAX_DEF,
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       running,
  output logic [3:0] data_min,
  output logic [3:0] data_sec_tens,
  output logic [3:0] data_sec_ones,
  output logic       loadn,
  output logic       carry_out,
  output logic [1:0] entry_cnt,
  output logic       err
);

  state_t       state;
  time_digits_t raw_q;    // r2 = minute, r1 = sec_tens, r0 = sec_ones
  time_digits_t data_q;   // last value presented to the counters
  time_digits_t norm;
  logic         norm_carry;
  logic         norm_clamp;

  logic digit_key;
  logic clear_key;
  logic load_key;

  // Key decode; codes 4'hC-4'hF decode to nothing and are dropped.
  assign digit_key = key_valid && is_digit(key_code);
  assign clear_key = key_valid && (key_code == KEY_CLEAR);
  assign load_key  = key_valid && (key_code == KEY_LOAD);

  time_normalizer #(
    .MIN_MAX      (MIN_MAX),
    .SEC_TENS_MAX (SEC_TENS_MAX)
  ) u_time_normalizer (
    .raw   (raw_q),
    .norm  (norm),
    .carry (norm_carry),
    .clamp (norm_clamp)
  );

  assign data_min      = data_q.minute;
  assign data_sec_tens = data_q.sec_tens;
  assign data_sec_ones = data_q.sec_ones;

  // Entry FSM, raw digit shift register and registered load interface.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!clearn) begin
      state     <= S_IDLE;
      raw_q     <= '0;
      entry_cnt <= 2'd0;
      data_q    <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
      loadn     <= 1'b1;
    end else begin
      // Strobes default to inactive; they are asserted for single cycles.
      loadn <= 1'b1;
      err   <= 1'b0;

      case (state)
        S_IDLE, S_ENTRY: begin
          if (clear_key) begin
            raw_q     <= '0;
            entry_cnt <= 2'd0;
            state     <= S_IDLE;
          end else if (digit_key && !running) begin
            // Newest digit enters at seconds-ones; a fourth digit pushes
            // the oldest one out of the minute position.
            raw_q.minute   <= raw_q.sec_tens;
            raw_q.sec_tens <= raw_q.sec_ones;
            raw_q.sec_ones <= key_code;
            if (entry_cnt != 2'd3) begin
              entry_cnt <= entry_cnt + 2'd1;
            end
            state <= S_ENTRY;
          end else if (load_key && !running) begin
            if (state == S_ENTRY) begin
              state <= S_NORM;
            end else begin
              // Nothing typed: reject the LOAD.
              err <= 1'b1;
            end
          end
        end

        S_NORM: begin
          if (clear_key) begin
            // Abort: no loadn pulse and the counters' data stay as they were.
            raw_q     <= '0;
            entry_cnt <= 2'd0;
            state     <= S_IDLE;
          end else begin
            data_q    <= norm;
            carry_out <= norm_carry;
            err       <= norm_clamp;
            loadn     <= 1'b0;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          // The counters sample the load at this edge; keys are ignored.
          carry_out <= 1'b0;
          raw_q     <= '0;
          entry_cnt <= 2'd0;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_time_loader.sv
// Self-checking bench for keypad_time_loader: directed scenarios plus a
// randomized run against a time-arithmetic reference model.
module tb_keypad_time_loader;

  localparam logic [3:0] K_CLEAR = 4'hA;
  localparam logic [3:0] K_LOAD  = 4'hB;

  logic       clk;
  logic       clearn;
  logic       key_valid;
  logic [3:0] key_code;
  logic       running;
  logic [3:0] data_min;
  logic [3:0] data_sec_tens;
  logic [3:0] data_sec_ones;
  logic       loadn;
  logic       carry_out;
  logic [1:0] entry_cnt;
  logic       err;

  int checks   = 0;
  int failures = 0;

  // Observations around one LOAD press at edge n.
  typedef struct {
    logic       err_n;
    logic       loadn_n;
    logic       loadn_n1;
    logic       carry_n1;
    logic       err_n1;
    logic [3:0] dmin_n1;
    logic [3:0] dst_n1;
    logic [3:0] dso_n1;
    logic       loadn_n2;
    logic       carry_n2;
    logic [1:0] cnt_n2;
    logic       err_n2;
  } load_obs_t;

  keypad_time_loader dut (
    .clk           (clk),
    .clearn        (clearn),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .running       (running),
    .data_min      (data_min),
    .data_sec_tens (data_sec_tens),
    .data_sec_ones (data_sec_ones),
    .loadn         (loadn),
    .carry_out     (carry_out),
    .entry_cnt     (entry_cnt),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Present one key (or idle) for exactly one rising edge, then sample 1ns after.
  task automatic step(input logic v, input logic [3:0] code);
    key_valid = v;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Press LOAD and record the outputs after edges n, n+1 and n+2.
  task automatic do_load(output load_obs_t o);
    step(1'b1, K_LOAD);
    o.err_n    = err;
    o.loadn_n  = loadn;
    step(1'b0, 4'h0);
    o.loadn_n1 = loadn;
    o.carry_n1 = carry_out;
    o.err_n1   = err;
    o.dmin_n1  = data_min;
    o.dst_n1   = data_sec_tens;
    o.dso_n1   = data_sec_ones;
    step(1'b0, 4'h0);
    o.loadn_n2 = loadn;
    o.carry_n2 = carry_out;
    o.cnt_n2   = entry_cnt;
    o.err_n2   = err;
  endtask

  // Reference: the counters should end up showing the typed time, with
  // seconds >= 60 rolled into the minute via carry, saturating at 9:59.
  task automatic model_load(input int r2, input int r1, input int r0,
                            output int e_min, output int e_st, output int e_so,
                            output logic e_carry, output logic e_clamp);
    int secs;
    int total;
    secs  = r1 * 10 + r0;
    total = r2 * 60 + secs;
    if (total >= 600) begin
      e_min = 9; e_st = 5; e_so = 9; e_carry = 1'b0; e_clamp = 1'b1;
    end else begin
      e_carry = (secs >= 60);
      e_clamp = 1'b0;
      e_min   = total / 60 - (e_carry ? 1 : 0);
      e_st    = (total % 60) / 10;
      e_so    = total % 10;
    end
  endtask

  task automatic test_reset();
    clearn = 1'b0; running = 1'b0;
    step(1'b0, 4'h0);
    step(1'b1, 4'h7);
    checks++;
    if ({loadn, carry_out, err, entry_cnt, data_min, data_sec_tens, data_sec_ones} !== {1'b1, 1'b0, 1'b0, 2'd0, 12'h000}) begin
      failures++;
      $display("FAIL reset_outputs: got loadn=%b carry=%b err=%b cnt=%0d data=%h/%h/%h want 1/0/0/0 data=0/0/0",
               loadn, carry_out, err, entry_cnt, data_min, data_sec_tens, data_sec_ones);
    end
    clearn = 1'b1;
    step(1'b0, 4'h0);
  endtask

  task automatic test_basic_load();
    load_obs_t o;
    step(1'b1, 4'd1); step(1'b1, 4'd2); step(1'b1, 4'd3);
    checks++;
    if (entry_cnt !== 2'd3) begin
      failures++; $display("FAIL basic_cnt: got %0d want 3", entry_cnt);
    end
    do_load(o);
    checks++;
    if (o.loadn_n !== 1'b1) begin
      failures++; $display("FAIL basic_loadn_early: got %b want 1", o.loadn_n);
    end
    checks++;
    if ({o.loadn_n1, o.dmin_n1, o.dst_n1, o.dso_n1, o.carry_n1} !== {1'b0, 4'd1, 4'd2, 4'd3, 1'b0}) begin
      failures++;
      $display("FAIL basic_load: got loadn=%b data=%0d/%0d/%0d carry=%b want 0 data=1/2/3 carry=0",
               o.loadn_n1, o.dmin_n1, o.dst_n1, o.dso_n1, o.carry_n1);
    end
    checks++;
    if ({o.loadn_n2, o.cnt_n2} !== {1'b1, 2'd0}) begin
      failures++; $display("FAIL basic_after: got loadn=%b cnt=%0d want 1/0", o.loadn_n2, o.cnt_n2);
    end
  endtask

  task automatic test_carry();
    load_obs_t o;
    step(1'b1, 4'd7); step(1'b1, 4'd5);
    do_load(o);
    checks++;
    if ({o.loadn_n1, o.dmin_n1, o.dst_n1, o.dso_n1, o.carry_n1} !== {1'b0, 4'd0, 4'd1, 4'd5, 1'b1}) begin
      failures++;
      $display("FAIL carry_load: got loadn=%b data=%0d/%0d/%0d carry=%b want 0 data=0/1/5 carry=1",
               o.loadn_n1, o.dmin_n1, o.dst_n1, o.dso_n1, o.carry_n1);
    end
    checks++;
    if (o.carry_n2 !== 1'b0) begin
      failures++; $display("FAIL carry_drop: got %b want 0", o.carry_n2);
    end
  endtask

  task automatic test_clamp();
    load_obs_t o;
    step(1'b1, 4'd9); step(1'b1, 4'd8); step(1'b1, 4'd0);
    do_load(o);
    checks++;
    if ({o.dmin_n1, o.dst_n1, o.dso_n1, o.carry_n1, o.loadn_n1} !== {4'd9, 4'd5, 4'd9, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clamp_load: got data=%0d/%0d/%0d carry=%b loadn=%b want 9/5/9 carry=0 loadn=0",
               o.dmin_n1, o.dst_n1, o.dso_n1, o.carry_n1, o.loadn_n1);
    end
    checks++;
    if ({o.err_n, o.err_n1, o.err_n2} !== 3'b010) begin
      failures++; $display("FAIL clamp_err: got %b%b%b want 010", o.err_n, o.err_n1, o.err_n2);
    end
  endtask

  task automatic test_overflow_entry();
    load_obs_t o;
    step(1'b1, 4'd1); step(1'b1, 4'd2); step(1'b1, 4'd3); step(1'b1, 4'd4);
    checks++;
    if (entry_cnt !== 2'd3) begin
      failures++; $display("FAIL overflow_cnt: got %0d want 3", entry_cnt);
    end
    do_load(o);
    checks++;
    if ({o.dmin_n1, o.dst_n1, o.dso_n1} !== {4'd2, 4'd3, 4'd4}) begin
      failures++; $display("FAIL overflow_data: got %0d/%0d/%0d want 2/3/4", o.dmin_n1, o.dst_n1, o.dso_n1);
    end
  endtask

  task automatic test_idle_load();
    load_obs_t o;
    do_load(o);
    checks++;
    if ({o.err_n, o.err_n1, o.loadn_n, o.loadn_n1, o.loadn_n2} !== 5'b10111) begin
      failures++;
      $display("FAIL idle_load: got err=%b%b loadn=%b%b%b want err=10 loadn=111",
               o.err_n, o.err_n1, o.loadn_n, o.loadn_n1, o.loadn_n2);
    end
    checks++;
    if ({data_min, data_sec_tens, data_sec_ones} !== {4'd2, 4'd3, 4'd4}) begin
      failures++; $display("FAIL idle_data_hold: got %0d/%0d/%0d want 2/3/4", data_min, data_sec_tens, data_sec_ones);
    end
  endtask

  task automatic test_abort();
    logic seen_low;
    seen_low = 1'b0;
    step(1'b1, 4'd4);
    step(1'b1, K_LOAD);  seen_low |= ~loadn;
    step(1'b1, K_CLEAR); seen_low |= ~loadn;
    step(1'b0, 4'h0);    seen_low |= ~loadn;
    step(1'b0, 4'h0);    seen_low |= ~loadn;
    checks++;
    if (seen_low !== 1'b0) begin
      failures++; $display("FAIL abort_loadn: got low pulse=%b want 0", seen_low);
    end
    checks++;
    if ({data_min, data_sec_tens, data_sec_ones, entry_cnt} !== {4'd2, 4'd3, 4'd4, 2'd0}) begin
      failures++;
      $display("FAIL abort_hold: got data=%0d/%0d/%0d cnt=%0d want 2/3/4 cnt=0",
               data_min, data_sec_tens, data_sec_ones, entry_cnt);
    end
  endtask

  task automatic test_running();
    logic seen_low;
    logic seen_err;
    running = 1'b1;
    step(1'b1, 4'd5);
    checks++;
    if (entry_cnt !== 2'd0) begin
      failures++; $display("FAIL running_digit: got cnt=%0d want 0", entry_cnt);
    end
    step(1'b1, K_LOAD); seen_low = ~loadn; seen_err = err;
    step(1'b0, 4'h0);   seen_low |= ~loadn; seen_err |= err;
    step(1'b0, 4'h0);   seen_low |= ~loadn; seen_err |= err;
    checks++;
    if ({seen_low, seen_err} !== 2'b00) begin
      failures++; $display("FAIL running_load: got loadn_low=%b err=%b want 0/0", seen_low, seen_err);
    end
    // CLEAR still works while running.
    running = 1'b0;
    step(1'b1, 4'd1); step(1'b1, 4'd2);
    running = 1'b1;
    step(1'b1, K_CLEAR);
    checks++;
    if (entry_cnt !== 2'd0) begin
      failures++; $display("FAIL running_clear: got cnt=%0d want 0", entry_cnt);
    end
    running = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    step(1'b1, 4'd1); step(1'b1, 4'd2); step(1'b1, 4'd3);
    step(1'b1, K_LOAD);
    step(1'b0, 4'h0);   // now in S_LOAD with loadn low
    checks++;
    if (loadn !== 1'b0) begin
      failures++; $display("FAIL rst_load_setup: got loadn=%b want 0", loadn);
    end
    clearn = 1'b0;
    step(1'b0, 4'h0);
    checks++;
    if ({loadn, carry_out, err, entry_cnt, data_min, data_sec_tens, data_sec_ones} !== {1'b1, 1'b0, 1'b0, 2'd0, 12'h000}) begin
      failures++;
      $display("FAIL rst_in_load: got loadn=%b carry=%b err=%b cnt=%0d data=%h/%h/%h want 1/0/0/0 data=0/0/0",
               loadn, carry_out, err, entry_cnt, data_min, data_sec_tens, data_sec_ones);
    end
    clearn = 1'b1;
    // Reset while in S_NORM: no load may follow.
    step(1'b1, 4'd6); step(1'b1, K_LOAD);
    clearn = 1'b0;
    step(1'b0, 4'h0);
    clearn = 1'b1;
    step(1'b0, 4'h0);
    checks++;
    if ({loadn, data_sec_ones} !== {1'b1, 4'd0}) begin
      failures++; $display("FAIL rst_in_norm: got loadn=%b sec_ones=%0d want 1/0", loadn, data_sec_ones);
    end
  endtask

  task automatic test_random();
    int q[$];
    int n_keys, d, r2, r1, r0, e_min, e_st, e_so, sz;
    logic e_carry, e_clamp;
    load_obs_t o;
    for (int it = 0; it < 150; it++) begin
      q.delete();
      n_keys = $urandom_range(0, 6);
      for (int k = 0; k < n_keys; k++) begin
        case ($urandom_range(0, 9))
          0: begin step(1'b1, 4'($urandom_range(12, 15))); end
          1: begin
               running = 1'b1;
               step(1'b1, 4'($urandom_range(0, 9)));
               running = 1'b0;
             end
          2: begin step(1'b1, K_CLEAR); q.delete(); end
          default: begin
               d = $urandom_range(0, 9);
               step(1'b1, 4'(d));
               q.push_back(d);
               if (q.size() > 3) void'(q.pop_front());
             end
        endcase
      end
      sz = q.size();
      checks++;
      if (entry_cnt !== 2'(sz)) begin
        failures++; $display("FAIL rand_cnt it=%0d: got %0d want %0d", it, entry_cnt, sz);
      end
      do_load(o);
      if (sz == 0) begin
        checks++;
        if ({o.err_n, o.loadn_n1, o.loadn_n2} !== 3'b111) begin
          failures++;
          $display("FAIL rand_empty it=%0d: got err=%b loadn=%b%b want err=1 loadn=11", it, o.err_n, o.loadn_n1, o.loadn_n2);
        end
      end else begin
        r0 = q[sz-1];
        r1 = (sz >= 2) ? q[sz-2] : 0;
        r2 = (sz >= 3) ? q[sz-3] : 0;
        model_load(r2, r1, r0, e_min, e_st, e_so, e_carry, e_clamp);
        checks++;
        if ({o.loadn_n, o.loadn_n1, o.loadn_n2, o.dmin_n1, o.dst_n1, o.dso_n1, o.carry_n1, o.err_n, o.err_n1, o.cnt_n2}
            !== {1'b1, 1'b0, 1'b1, 4'(e_min), 4'(e_st), 4'(e_so), e_carry, 1'b0, e_clamp, 2'd0}) begin
          failures++;
          $display("FAIL rand_load it=%0d raw=%0d%0d%0d: got loadn=%b%b%b data=%0d/%0d/%0d carry=%b err=%b%b cnt=%0d want loadn=101 data=%0d/%0d/%0d carry=%b err=0%b cnt=0",
                   it, r2, r1, r0, o.loadn_n, o.loadn_n1, o.loadn_n2, o.dmin_n1, o.dst_n1, o.dso_n1,
                   o.carry_n1, o.err_n, o.err_n1, o.cnt_n2, e_min, e_st, e_so, e_carry, e_clamp);
        end
      end
    end
  endtask

  initial begin
    clearn    = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    running   = 1'b0;
    test_reset();
    test_basic_load();
    test_carry();
    test_clamp();
    test_overflow_entry();
    test_idle_load();
    test_abort();
    test_running();
    test_reset_mid_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
